ran_harvester: RTL and testbench
================================

Name: ran_harvester

Overview:
- Consumer side of the dual-latch entropy array.
- Drives the array enable and samples the N_BLOCKS raw latch outputs through a synchronizer.
- XOR-reduces the synchronized outputs to one raw bit per cycle, applies von Neumann debiasing, and packs accepted bits into WORD_W-bit words.
- Offers each word to the downstream consumer over a valid/ready handshake.

Parameters:
- N_BLOCKS, 12: width of the entropy-array output bus.
- WORD_W, 32: bits per output word; must be at least 2.
- SYNC_STAGES, 2: flop stages on each raw input bit; must be at least 2.
- SETTLE_CYCLES, 16: cycles the array stays enabled before the first sample; must be at least SYNC_STAGES.
- REP_LIMIT, 64: repetition limit for the health check; used only with the optional feature.

Ports:
- i_clock, in, 1: single clock.
- i_reset, in, 1: synchronous reset, active-high.
- i_run, in, 1: harvesting requested while high.
- o_enb, out, 1: enable to the entropy array.
- i_block_Qs, in, N_BLOCKS: raw asynchronous latch outputs.
- o_data, out, WORD_W: harvested word.
- o_valid, out, 1: o_data is valid.
- i_ready, in, 1: consumer accepts the word.
- o_busy, out, 1: FSM is not in IDLE.
- o_health_fail, out, 1: sticky health-test failure (optional feature only).

Behaviour:
- Reset: one clock and synchronous active-high reset are fixed. On the clock edge with i_reset=1:
  - state=IDLE; o_enb=0, o_valid=0, o_busy=0, o_data=0, o_health_fail=0.
  - Synchronizer flops, shift register, bit count, settle counter and pair phase all cleared.
  - Reset asserted mid-operation discards the partial word and any presented word.
- Synchronizer: SYNC_STAGES flops per bit, clocked in every state.
- Raw bit r: XOR of all bits of the last synchronizer stage. Combinational; valid every cycle.
- State IDLE:
  - o_enb=0.
  - i_run=1 -> SETTLE; o_enb=1 from the next cycle; settle counter=0.
- State SETTLE:
  - o_enb=1; counter increments each cycle.
  - When the counter reaches SETTLE_CYCLES-1 -> SAMPLE; pair phase=0; bit count=0.
  - i_run=0 -> IDLE.
- State SAMPLE (o_enb=1). Each cycle:
  - Phase 0: store r as a; phase<=1.
  - Phase 1: phase<=0. If a != r, shift a in at the LSB (word <= {word[WORD_W-2:0], a}) and increment the count. If a == r, discard both bits.
  - When an accept brings the count to WORD_W, that same edge loads o_data with the new word, sets o_valid=1, and moves to PRESENT.
  - i_run=0 -> IDLE; partial word discarded; count=0.
- State PRESENT:
  - o_enb stays high; sampling is suspended; phase held at 0.
  - o_valid=1; o_data stable until the transfer.
  - Transfer when o_valid & i_ready; o_valid=0 on the next cycle.
  - If i_run=1 at the transfer -> SAMPLE with count=0. If i_run=0 -> IDLE.
  - i_run deasserting before the transfer does not drop o_valid; the word is still delivered.
  - i_ready high before o_valid has no effect.
- o_busy: 1 in SETTLE, SAMPLE and PRESENT.
- Minimum latency from SAMPLE entry to o_valid: 2*WORD_W cycles, when every pair is accepted.
- Count width: clog2(WORD_W+1). The count never wraps, because reaching WORD_W always forces PRESENT.

Optional Feature:
- Macro: RAN_HARVEST_HEALTH_CHECK_EN.
- When defined:
  - A repetition counter runs in SAMPLE only and compares r with its previous value: equal -> increment (saturating); different -> counter=1.
  - When the counter reaches REP_LIMIT, o_health_fail is set. It is sticky until i_reset.
  - While o_health_fail=1: no words are accepted, o_valid is held 0, and the FSM is forced to IDLE with o_enb=0.
  - A word already in PRESENT when the failure is detected is delivered normally first.
- When undefined:
  - o_health_fail is tied 0 and no counter is built.
  - The port remains on the module.

Test Plan:
- Reset: i_reset=1 for 2 cycles with i_run=1 and i_block_Qs=12'hFFF -> o_enb=0, o_valid=0, o_busy=0, o_data=0.
- Alternating-XOR source (i_block_Qs toggles 12'h001/12'h000 each cycle) with i_ready=1:
  - o_enb rises 1 cycle after i_run.
  - o_valid rises exactly SETTLE_CYCLES+64 cycles after o_enb rises.
  - o_data=32'hFFFFFFFF, or 32'h00000000 depending on pair alignment; the bench checks against its model.
- Backpressure: hold i_ready=0 for 20 cycles after o_valid -> o_data and o_valid stable. Then i_ready=1 for 1 cycle -> o_valid=0 next cycle and count restarts at 0.
- Constant source 12'h0F0: i_run=1 for 500 cycles -> o_valid never asserts; o_busy=1 throughout.
- Abort: deassert i_run after 30 SAMPLE cycles -> IDLE next cycle, o_enb=0. Restarting must re-run SETTLE and produce a fresh full word, with no partial bits kept.
- With RAN_HARVEST_HEALTH_CHECK_EN and a constant source:
  - o_health_fail=1 after REP_LIMIT=64 SAMPLE cycles; o_enb=0 the next cycle.
  - o_health_fail stays set with i_run=1 until i_reset.

Source files
------------

// File: rtl/ran_harvester.sv
// ran_harvester: entropy-array consumer. It synchronizes and XOR-reduces the raw latch bus,
// applies von Neumann debiasing and packs the accepted bits into handshaked words.
// Optional repetition health test: define RAN_HARVEST_HEALTH_CHECK_EN.
module ran_harvester #(
    parameter int N_BLOCKS      = 12,
    parameter int WORD_W        = 32,
    parameter int SYNC_STAGES   = 2,
    parameter int SETTLE_CYCLES = 16,
    parameter int REP_LIMIT     = 64
) (
    input  logic                i_clock,
    input  logic                i_reset,
    input  logic                i_run,
    output logic                o_enb,
    input  logic [N_BLOCKS-1:0] i_block_Qs,
    output logic [WORD_W-1:0]   o_data,
    output logic                o_valid,
    input  logic                i_ready,
    output logic                o_busy,
    output logic                o_health_fail
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_SETTLE  = 2'd1;
    localparam logic [1:0] ST_SAMPLE  = 2'd2;
    localparam logic [1:0] ST_PRESENT = 2'd3;

    localparam int CNT_W = $clog2(WORD_W + 1);
    localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    if (WORD_W < 2) begin : g_bad_word_w
        $error("WORD_W must be at least 2");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("SYNC_STAGES must be at least 2");
    end
    if (SETTLE_CYCLES < SYNC_STAGES) begin : g_bad_settle
        $error("SETTLE_CYCLES must be at least SYNC_STAGES");
    end
    if (REP_LIMIT < 1) begin : g_bad_rep
        $error("REP_LIMIT must be at least 1");
    end

    logic [N_BLOCKS-1:0] sync_q [SYNC_STAGES];
    logic                raw_bit;
    logic                health_fail;

    logic [1:0]        state_q, state_d;
    logic [SET_W-1:0]  settle_q, settle_d;
    logic              phase_q, phase_d;
    logic              a_q, a_d;
    logic [WORD_W-2:0] word_q, word_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
    logic [WORD_W-1:0] data_q, data_d, shifted;
    logic              valid_q, valid_d;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= i_block_Qs;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign raw_bit = ^sync_q[SYNC_STAGES-1];

`ifdef RAN_HARVEST_HEALTH_CHECK_EN
    localparam int REP_W = $clog2(REP_LIMIT + 1);

    logic [REP_W-1:0] rep_q, rep_d;
    logic             prev_q, prev_d;
    logic             fail_q, fail_d;

    always_comb begin
        rep_d  = '0;
        prev_d = prev_q;
        fail_d = fail_q;
        if (state_q == ST_SAMPLE) begin
            prev_d = raw_bit;
            if (rep_q == '0 || raw_bit != prev_q) rep_d = REP_W'(1);
            else if (rep_q == REP_W'(REP_LIMIT))  rep_d = rep_q;
            else                                  rep_d = rep_q + 1'b1;
            if (rep_d == REP_W'(REP_LIMIT)) fail_d = 1'b1;
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            rep_q  <= '0;
            prev_q <= 1'b0;
            fail_q <= 1'b0;
        end else begin
            rep_q  <= rep_d;
            prev_q <= prev_d;
            fail_q <= fail_d;
        end
    end

    assign health_fail = fail_q;
`else
    assign health_fail = 1'b0;
`endif

    // The partial word holds only WORD_W-1 bits; the final accept is merged straight into o_data.
    assign shifted = {word_q, a_q};
    assign cnt_inc = cnt_q + 1'b1;

    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        phase_d  = phase_q;
        a_d      = a_q;
        word_d   = word_q;
        cnt_d    = cnt_q;
        data_d   = data_q;
        valid_d  = valid_q;
        case (state_q)
            ST_IDLE: begin
                settle_d = '0;
                if (i_run && !health_fail) state_d = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (!i_run || health_fail) begin
                    state_d = ST_IDLE;
                end else if (settle_q == SET_W'(SETTLE_CYCLES - 1)) begin
                    state_d = ST_SAMPLE;
                    phase_d = 1'b0;
                    cnt_d   = '0;
                end else begin
                    settle_d = settle_q + 1'b1;
                end
            end
            ST_SAMPLE: begin
                if (!i_run || health_fail) begin
                    state_d = ST_IDLE;
                    phase_d = 1'b0;
                    cnt_d   = '0;
                end else if (!phase_q) begin
                    a_d     = raw_bit;
                    phase_d = 1'b1;
                end else begin
                    phase_d = 1'b0;
                    if (a_q != raw_bit) begin
                        word_d = shifted[WORD_W-2:0];
                        if (cnt_inc == CNT_W'(WORD_W)) begin
                            data_d  = shifted;
                            valid_d = 1'b1;
                            cnt_d   = '0;
                            state_d = ST_PRESENT;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end
                end
            end
            default: begin
                phase_d = 1'b0;
                if (valid_q && i_ready) begin
                    valid_d = 1'b0;
                    cnt_d   = '0;
                    state_d = (i_run && !health_fail) ? ST_SAMPLE : ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q  <= ST_IDLE;
            settle_q <= '0;
            phase_q  <= 1'b0;
            a_q      <= 1'b0;
            word_q   <= '0;
            cnt_q    <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            settle_q <= settle_d;
            phase_q  <= phase_d;
            a_q      <= a_d;
            word_q   <= word_d;
            cnt_q    <= cnt_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
        end
    end

    assign o_enb         = (state_q != ST_IDLE);
    assign o_busy        = (state_q != ST_IDLE);
    assign o_data        = data_q;
    assign o_valid       = valid_q;
    assign o_health_fail = health_fail;

endmodule

// File: tb/tb_ran_harvester.sv
// Scoreboard bench for ran_harvester: a queue-based reference model predicts words and
// their presentation cycle; a negedge monitor pops and compares whenever o_valid appears.
module tb_ran_harvester;

    localparam int N  = 12;
    localparam int W  = 32;
    localparam int S  = 2;
    localparam int SC = 16;
    localparam int RL = 64;

    logic         i_clock = 1'b0;
    logic         i_reset = 1'b1;
    logic         i_run = 1'b0;
    logic         i_ready = 1'b0;
    logic [N-1:0] i_block_Qs = '0;
    logic         o_enb, o_valid, o_busy, o_health_fail;
    logic [W-1:0] o_data;

    ran_harvester #(
        .N_BLOCKS(N), .WORD_W(W), .SYNC_STAGES(S), .SETTLE_CYCLES(SC), .REP_LIMIT(RL)
    ) dut (
        .i_clock(i_clock), .i_reset(i_reset), .i_run(i_run), .o_enb(o_enb),
        .i_block_Qs(i_block_Qs), .o_data(o_data), .o_valid(o_valid),
        .i_ready(i_ready), .o_busy(o_busy), .o_health_fail(o_health_fail)
    );

    always #5 i_clock = ~i_clock;

    int cyc = 0;
    always @(posedge i_clock) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    typedef enum int {M_IDLE, M_SETTLE, M_SAMPLE, M_HOLD} mmode_t;
    typedef struct { logic [W-1:0] word; int cyc; } exp_t;

    mmode_t m_mode;
    int     m_settle, m_hold_age, m_sample_age, m_run_len;
    bit     m_fail, m_last_r;
    bit     m_pair[$];
    bit     m_bits[$];
    bit     m_rpipe[$];
    exp_t   exp_q[$];

    task automatic model_reset();
        m_mode = M_IDLE;
        m_settle = 0; m_hold_age = 0; m_sample_age = 0; m_run_len = 0;
        m_fail = 1'b0; m_last_r = 1'b0;
        m_pair.delete(); m_bits.delete(); m_rpipe.delete();
        for (int i = 0; i < S; i++) m_rpipe.push_back(1'b0);
    endtask

    task automatic enter_sample();
        m_mode = M_SAMPLE;
        m_pair.delete(); m_bits.delete();
        m_sample_age = 0; m_run_len = 0;
    endtask

    task automatic model_step(input bit rst, input bit run, input bit rdy, input logic [N-1:0] qs);
        bit r, fail_next;
        logic [W-1:0] wd;
        exp_t e;
        if (rst) begin
            model_reset();
            return;
        end
        r = m_rpipe.pop_front();
        m_rpipe.push_back(^qs);
        fail_next = m_fail;
        case (m_mode)
            M_IDLE: if (run && !m_fail) begin m_mode = M_SETTLE; m_settle = 0; end
            M_SETTLE: begin
                if (!run || m_fail) m_mode = M_IDLE;
                else if (m_settle == SC - 1) enter_sample();
                else m_settle++;
            end
            M_SAMPLE: begin
`ifdef RAN_HARVEST_HEALTH_CHECK_EN
                if (m_run_len == 0 || r != m_last_r) m_run_len = 1;
                else if (m_run_len < RL) m_run_len++;
                m_last_r = r;
                if (m_run_len >= RL) fail_next = 1'b1;
`endif
                if (!run || m_fail) begin
                    m_mode = M_IDLE;
                end else begin
                    m_sample_age++;
                    m_pair.push_back(r);
                    if (m_pair.size() == 2) begin
                        if (m_pair[0] != m_pair[1]) m_bits.push_back(m_pair[0]);
                        m_pair.delete();
                        if (m_bits.size() == W) begin
                            for (int i = 0; i < W; i++) wd[W-1-i] = m_bits[i];
                            e.word = wd;
                            e.cyc  = cyc;
                            exp_q.push_back(e);
                            m_mode = M_HOLD;
                            m_hold_age = 0;
                        end
                    end
                end
            end
            M_HOLD: begin
                m_hold_age++;
                if (rdy) begin
                    if (run && !m_fail) enter_sample();
                    else m_mode = M_IDLE;
                end
            end
            default: m_mode = M_IDLE;
        endcase
        m_fail = fail_next;
    endtask

    task automatic drive(input bit rst, input bit run, input bit rdy, input logic [N-1:0] qs);
        i_reset = rst; i_run = run; i_ready = rdy; i_block_Qs = qs;
        @(posedge i_clock);
        #1;
        model_step(rst, run, rdy, qs);
        chk("enb", o_enb, m_mode != M_IDLE);
        chk("busy", o_busy, m_mode != M_IDLE);
        chk("valid", o_valid, m_mode == M_HOLD);
        chk("health_fail", o_health_fail, m_fail);
    endtask

    // ---------------- monitor ----------------
    bit           shown = 1'b0;
    bit           prev_enb = 1'b0;
    bit           lat_armed = 1'b0;
    int           enb_rise = 0;
    logic [W-1:0] held;
    exp_t         got;

    initial begin
        forever begin
            @(negedge i_clock);
            if (o_enb === 1'b1 && !prev_enb) enb_rise = cyc;
            prev_enb = (o_enb === 1'b1);
            if (o_valid === 1'b1 && !shown) begin
                shown = 1'b1;
                held  = o_data;
                if (exp_q.size() == 0) begin
                    chk("word_expected", 0, 1);
                end else begin
                    got = exp_q.pop_front();
                    chk("word_data", o_data, got.word);
                    chk("word_cycle", cyc, got.cyc);
                    if (lat_armed) begin
                        chk("enb_to_valid_latency", cyc - enb_rise, SC + 2 * W);
                        lat_armed = 1'b0;
                    end
                end
            end else if (o_valid === 1'b1) begin
                chk("data_stable", o_data, held);
            end
            if (o_valid !== 1'b1) shown = 1'b0;
        end
    end

    // ---------------- stimulus ----------------
    bit rdy;
    bit reached;

    initial begin
        model_reset();

        drive(1, 1, 0, 12'hFFF);
        drive(1, 1, 0, 12'hFFF);
        chk("reset_enb", o_enb, 0);
        chk("reset_valid", o_valid, 0);
        chk("reset_busy", o_busy, 0);
        chk("reset_data", o_data, 0);
        chk("reset_health", o_health_fail, 0);
        for (int i = 0; i < 3; i++) drive(0, 0, 0, '0);

        // Alternating XOR source, consumer always ready.
        lat_armed = 1'b1;
        for (int i = 0; i < 100; i++) begin
            drive(0, 1, 1, (i % 2) ? 12'h001 : 12'h000);
            if (i == 0) chk("enb_one_cycle_after_run", o_enb, 1);
        end
        // Backpressure: consumer waits 20 cycles after each presentation.
        for (int i = 0; i < 150; i++) begin
            rdy = (m_mode == M_HOLD && m_hold_age >= 20);
            drive(0, 1, rdy, (i % 2) ? 12'h001 : 12'h000);
        end
        // Run drops while a word may be pending; it must still be delivered.
        for (int i = 0; i < 40; i++) begin
            rdy = (m_mode == M_HOLD && m_hold_age >= 20);
            drive(0, 0, rdy, (i % 2) ? 12'h001 : 12'h000);
        end

        // Constant source: no pair is ever accepted.
        for (int i = 0; i < 500; i++) drive(0, 1, 1, 12'h0F0);
        for (int i = 0; i < 3; i++) drive(0, 0, 1, '0);
        drive(1, 0, 0, '0);
        for (int i = 0; i < 2; i++) drive(0, 0, 0, '0);

        // Abort after 30 SAMPLE cycles, then restart with random data and random ready.
        reached = 1'b0;
        for (int i = 0; i < 200 && !reached; i++) begin
            drive(0, 1, 1, N'($urandom));
            reached = (m_mode == M_SAMPLE && m_sample_age >= 30);
        end
        chk("abort_reached_sample", reached, 1);
        drive(0, 0, 1, N'($urandom));
        chk("abort_enb_low", o_enb, 0);
        chk("abort_busy_low", o_busy, 0);
        for (int i = 0; i < 3; i++) drive(0, 0, 1, N'($urandom));
        for (int i = 0; i < 400; i++) drive(0, 1, 1'($urandom_range(0, 1)), N'($urandom));
        for (int i = 0; i < 10; i++) drive(0, 0, 1, N'($urandom));

`ifdef RAN_HARVEST_HEALTH_CHECK_EN
        drive(1, 0, 0, '0);
        for (int i = 0; i < 100; i++) drive(0, 1, 1, 12'h0F0);
        chk("health_fail_sticky", o_health_fail, 1);
        chk("health_enb_low", o_enb, 0);
        drive(1, 1, 1, 12'h0F0);
        chk("health_cleared_by_reset", o_health_fail, 0);
        drive(0, 0, 0, '0);
`endif

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
